// File: rtl/id_ex_stage_hz_if.sv
// Bundle between the IF/ID latch, writeback and the EX stage around the ID/EX register.
// master drives the ID-side inputs; slave is the decode stage itself.
interface id_ex_stage_hz_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       instr_in;
    logic [DATA_W-1:0] npc_in;
    logic              valid_in;
    logic              reg_write;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              flush;
    logic              stall_out;
    logic              valid_out;
    logic [1:0]        wb_out;
    logic [2:0]        m_out;
    logic [3:0]        ex_out;
    logic [DATA_W-1:0] npc_out;
    logic [DATA_W-1:0] rd1_out;
    logic [DATA_W-1:0] rd2_out;
    logic [DATA_W-1:0] sign_out;
    logic [4:0]        rs_out;
    logic [4:0]        rt_out;
    logic [4:0]        rd_out;

    modport master (
        output instr_in, npc_in, valid_in, reg_write, wr_addr, wr_data, flush,
        input  stall_out, valid_out, wb_out, m_out, ex_out, npc_out,
               rd1_out, rd2_out, sign_out, rs_out, rt_out, rd_out
    );

    modport slave (
        input  instr_in, npc_in, valid_in, reg_write, wr_addr, wr_data, flush,
        output stall_out, valid_out, wb_out, m_out, ex_out, npc_out,
               rd1_out, rd2_out, sign_out, rs_out, rt_out, rd_out
    );
endinterface

// File: rtl/id_ex_stage_hz.sv
// MIPS decode stage with register file, WB bypass, load-use stall detection
// and the ID/EX pipeline register with flush/bubble insertion.
module id_ex_stage_hz #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    parameter int HAZARD = 1
) (
    input logic             clk,
    input logic             rst,
    id_ex_stage_hz_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];

    logic              valid_q, valid_d;
    logic [1:0]        wb_q, wb_d;
    logic [2:0]        m_q, m_d;
    logic [3:0]        ex_q, ex_d;
    logic [DATA_W-1:0] npc_q, npc_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] sign_q, sign_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;

    logic [4:0] rs_a, rt_a;
    logic       wr_en;
    logic       stall;
    logic       bubble;
    logic [8:0] ctrl;

    assign rs_a  = bus.instr_in[25:21];
    assign rt_a  = bus.instr_in[20:16];
    assign wr_en = bus.reg_write && (bus.wr_addr != 5'd0) && (int'(bus.wr_addr) < NREG);

    // A load in ID/EX whose rt feeds the instruction now in ID must wait one cycle.
    assign stall = (HAZARD != 0) && !rst && valid_q && m_q[1] && bus.valid_in &&
                   (rt_q != 5'd0) && ((rt_q == rs_a) || (rt_q == rt_a));
    assign bubble = bus.flush || stall;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (bus.wr_addr == 5'(i)))
                regs_d[i] = bus.wr_data;
        end
    end

    always_comb begin
        ctrl = 9'b0;
        if (bus.valid_in) begin
            case (bus.instr_in[31:26])
                OP_RTYPE: ctrl = {2'b10, 3'b000, 4'b1100};
                OP_LW:    ctrl = {2'b11, 3'b010, 4'b0001};
                OP_SW:    ctrl = {2'b00, 3'b001, 4'b0001};
                OP_BEQ:   ctrl = {2'b00, 3'b100, 4'b0010};
                default:  ctrl = 9'b0;
            endcase
        end
    end

    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if ((rs_a != 5'd0) && (int'(rs_a) < NREG))
            rd1_d = ((BYPASS != 0) && wr_en && (bus.wr_addr == rs_a)) ? bus.wr_data : regs_q[rs_a];
        if ((rt_a != 5'd0) && (int'(rt_a) < NREG))
            rd2_d = ((BYPASS != 0) && wr_en && (bus.wr_addr == rt_a)) ? bus.wr_data : regs_q[rt_a];

        valid_d = bus.valid_in && !bubble;
        wb_d    = bubble ? 2'b0 : ctrl[8:7];
        m_d     = bubble ? 3'b0 : ctrl[6:4];
        ex_d    = bubble ? 4'b0 : ctrl[3:0];
        npc_d   = bus.npc_in;
        sign_d  = {{(DATA_W-16){bus.instr_in[15]}}, bus.instr_in[15:0]};
        rs_d    = rs_a;
        rt_d    = rt_a;
        rd_d    = bus.instr_in[15:11];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            valid_q <= 1'b0;
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            npc_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            sign_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
            valid_q <= valid_d;
            wb_q    <= wb_d;
            m_q     <= m_d;
            ex_q    <= ex_d;
            npc_q   <= npc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            sign_q  <= sign_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.stall_out = stall;
    assign bus.valid_out = valid_q;
    assign bus.wb_out    = wb_q;
    assign bus.m_out     = m_q;
    assign bus.ex_out    = ex_q;
    assign bus.npc_out   = npc_q;
    assign bus.rd1_out   = rd1_q;
    assign bus.rd2_out   = rd2_q;
    assign bus.sign_out  = sign_q;
    assign bus.rs_out    = rs_q;
    assign bus.rt_out    = rt_q;
    assign bus.rd_out    = rd_q;
endmodule
